mux_valve_sequencer: RTL and testbench
======================================

// Module: mux_valve_sequencer
// PURPOSE
//  Digital initiator for the pneumatic control lines of the 4-outlet MUX valve tree
//  (ctrl1/ctrl2 gate inlet->branch0/branch1; ctrl3/ctrl4 gate branch0/branch1 ->
//  outlet pairs). Accepts a route request, opens the downstream valve before the
//  inlet valve, holds flow for a dwell time, then closes in reverse order so no
//  backflow reaches the other branch. Sits between the control host and the chip pins.
// PARAMETERS
//  SETTLE_CYCLES  16  cycles spent in each valve-transition state; legal range >=1
//  DWELL_W        16  width of req_dwell
//  CLOSED_LEVEL   1   ctrl output level that pressurises (closes) a valve
// PORTS
//  clk           in   1        single clock; all logic on rising edge
//  rst_n         in   1        synchronous reset, active low
//  req_valid     in   1        route request valid
//  req_ready     out  1        high only in IDLE; request accepted on valid&&ready
//  req_branch    in   1        0: ctrl1+ctrl3 path; 1: ctrl2+ctrl4 path
//  req_dwell     in   DWELL_W  cycles with both valves of the path open
//  abort         in   1        early termination of the active route
//  ctrl1..ctrl4  out  1 each   valve air lines, registered
//  busy          out  1        state != IDLE
//  done          out  1        one-cycle pulse when sequence completes
//  done_aborted  out  1        qualifies done: sequence ended by abort
// BEHAVIOUR
//  Reset: state=IDLE, all ctrlN=CLOSED_LEVEL, req_ready=1 (first cycle after reset
//   release), busy=0, done=0, done_aborted=0, counters=0. Reset mid-sequence closes
//   all valves on the next edge, drops the request and emits no done.
//  States: IDLE -> OPEN_OUT -> OPEN_IN -> DWELL -> CLOSE_IN -> CLOSE_OUT -> IDLE.
//  Accept at edge T: branch/dwell latched; OPEN_OUT occupies cycles T+1..T+S (S=SETTLE_CYCLES).
//  OPEN_OUT: downstream valve (ctrl3 or ctrl4) open; all other lines closed.
//  OPEN_IN (S cycles): downstream and inlet (ctrl1 or ctrl2) open.
//  DWELL (dwell cycles): same valve pattern as OPEN_IN; dwell=0 skips DWELL entirely.
//  CLOSE_IN (S cycles): inlet closed, downstream still open (drains branch).
//  CLOSE_OUT (S cycles): all closed. Then IDLE; done=1 and req_ready=1 in that same
//   first IDLE cycle. Total accept-to-done = 4*S + dwell + 1 cycles.
//  Ctrl outputs are a registered decode of next-state, so ctrl changes coincide with
//   state entry; the unselected branch's ctrl lines never leave CLOSED_LEVEL.
//  Dwell counter: loads req_dwell-1, decrements; width DWELL_W, no wrap (exits at 0).
//  Settle counter: loads S-1 on each state entry, exits at 0.
//  Abort (sampled while busy): OPEN_OUT -> CLOSE_OUT; OPEN_IN/DWELL -> CLOSE_IN; full S
//   settle still applied. Abort in CLOSE_IN/CLOSE_OUT ignored but still flags the
//   result. done_aborted=1 with done only if abort was seen during the sequence.
//  Abort in IDLE ignored; abort coinciding with acceptance is ignored (request starts).
//  req_valid while busy: held off (req_ready=0); no queueing.
//  Only one path may ever be open; an inlet valve is never open while its downstream
//   valve is closed.
// TESTING
//  S=4, branch0, dwell=10, accept T -> ctrl3 open T+1..T+22, ctrl1 open T+5..T+18,
//   ctrl2/ctrl4 closed throughout, done=1 and req_ready=1 only at T+27, done_aborted=0.
//  S=4, branch1, dwell=0 -> ctrl4 open T+1..T+12, ctrl2 open T+5..T+8, done at T+17.
//  S=4, branch0, dwell=100, abort at T+12 (DWELL) -> ctrl1 closes at T+13, ctrl3
//   closes at T+17, done=1 with done_aborted=1 at T+21.
//  Abort at T+2 (OPEN_OUT) -> ctrl1 never opens, ctrl3 closes T+3, done+aborted at T+7.
//  req_valid held high with alternating branches -> each accept exactly in done cycle;
//   back-to-back sequences, ctrl1 and ctrl2 never simultaneously open.
//  rst_n low at T+10 of an active route -> all ctrl=CLOSED_LEVEL next edge, no done,
//   req_ready=1 after release; abort in IDLE -> no state change.

Source files
------------

// File: rtl/mux_valve_sequencer_if.sv
// Route-request handshake between the control host and the MUX valve sequencer.
// The host presents branch and dwell with req_valid; the sequencer answers with req_ready.
interface mux_valve_sequencer_if #(
    parameter int unsigned DWELL_W = 16
);
    logic               req_valid;
    logic               req_ready;
    logic               req_branch;
    logic [DWELL_W-1:0] req_dwell;

    modport master (
        output req_valid,
        output req_branch,
        output req_dwell,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_branch,
        input  req_dwell,
        output req_ready
    );
endinterface

// File: rtl/mux_valve_sequencer.sv
// Drives the four pneumatic control lines of the MUX valve tree: it opens the downstream
// valve before the inlet, dwells, then closes the inlet before the downstream valve.
module mux_valve_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned DWELL_W       = 16,
    parameter bit          CLOSED_LEVEL  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux_valve_sequencer_if.slave   req,
    input  logic                   abort,
    output logic                   ctrl1,
    output logic                   ctrl2,
    output logic                   ctrl3,
    output logic                   ctrl4,
    output logic                   busy,
    output logic                   done,
    output logic                   done_aborted
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic OPEN_LEVEL = ~CLOSED_LEVEL;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] OPEN_OUT  = 3'd1;
    localparam logic [2:0] OPEN_IN   = 3'd2;
    localparam logic [2:0] DWELL     = 3'd3;
    localparam logic [2:0] CLOSE_IN  = 3'd4;
    localparam logic [2:0] CLOSE_OUT = 3'd5;

    logic [2:0]          state,      state_n;
    logic [SETTLE_W-1:0] settle_cnt, settle_n;
    logic [DWELL_W-1:0]  dwell_cnt,  dwell_n;
    logic [DWELL_W-1:0]  dwell_len,  dwell_len_n;
    logic                branch,     branch_n;
    logic                aborted,    aborted_n;
    logic                finish;
    logic                out_open,   in_open;
    logic [3:0]          ctrl_q,     ctrl_n;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;
    logic                done_ab_q;

    // Next-state, counter and latch logic
    always_comb begin
        state_n     = state;
        settle_n    = settle_cnt;
        dwell_n     = dwell_cnt;
        dwell_len_n = dwell_len;
        branch_n    = branch;
        aborted_n   = aborted;
        finish      = 1'b0;

        if (abort && (state != IDLE)) begin
            aborted_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (req.req_valid) begin
                    state_n     = OPEN_OUT;
                    settle_n    = SETTLE_LOAD;
                    branch_n    = req.req_branch;
                    dwell_len_n = req.req_dwell;
                    aborted_n   = 1'b0;
                end
            end
            OPEN_OUT: begin
                // Inlet never opened yet, so an abort can skip straight to the final close
                if (abort) begin
                    state_n  = CLOSE_OUT;
                    settle_n = SETTLE_LOAD;
                end else if (settle_cnt == '0) begin
                    state_n  = OPEN_IN;
                    settle_n = SETTLE_LOAD;
                end else begin
                    settle_n = settle_cnt - SETTLE_W'(1);
                end
            end
            OPEN_IN: begin
                if (abort) begin
                    state_n  = CLOSE_IN;
                    settle_n = SETTLE_LOAD;
                end else if (settle_cnt == '0) begin
                    if (dwell_len == '0) begin
                        state_n  = CLOSE_IN;
                        settle_n = SETTLE_LOAD;
                    end else begin
                        state_n = DWELL;
                        dwell_n = dwell_len - DWELL_W'(1);
                    end
                end else begin
                    settle_n = settle_cnt - SETTLE_W'(1);
                end
            end
            DWELL: begin
                if (abort || (dwell_cnt == '0)) begin
                    state_n  = CLOSE_IN;
                    settle_n = SETTLE_LOAD;
                end else begin
                    dwell_n = dwell_cnt - DWELL_W'(1);
                end
            end
            CLOSE_IN: begin
                if (settle_cnt == '0) begin
                    state_n  = CLOSE_OUT;
                    settle_n = SETTLE_LOAD;
                end else begin
                    settle_n = settle_cnt - SETTLE_W'(1);
                end
            end
            CLOSE_OUT: begin
                if (settle_cnt == '0) begin
                    state_n = IDLE;
                    finish  = 1'b1;
                end else begin
                    settle_n = settle_cnt - SETTLE_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Valve pattern decoded from the upcoming state so line changes coincide with state entry
    always_comb begin
        out_open  = (state_n == OPEN_OUT) || (state_n == OPEN_IN) ||
                    (state_n == DWELL)    || (state_n == CLOSE_IN);
        in_open   = (state_n == OPEN_IN)  || (state_n == DWELL);
        ctrl_n[0] = (in_open  && !branch_n) ? OPEN_LEVEL : CLOSED_LEVEL;
        ctrl_n[1] = (in_open  &&  branch_n) ? OPEN_LEVEL : CLOSED_LEVEL;
        ctrl_n[2] = (out_open && !branch_n) ? OPEN_LEVEL : CLOSED_LEVEL;
        ctrl_n[3] = (out_open &&  branch_n) ? OPEN_LEVEL : CLOSED_LEVEL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            dwell_cnt  <= '0;
            dwell_len  <= '0;
            branch     <= 1'b0;
            aborted    <= 1'b0;
            ctrl_q     <= {4{CLOSED_LEVEL}};
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_ab_q  <= 1'b0;
        end else begin
            state      <= state_n;
            settle_cnt <= settle_n;
            dwell_cnt  <= dwell_n;
            dwell_len  <= dwell_len_n;
            branch     <= branch_n;
            aborted    <= aborted_n;
            ctrl_q     <= ctrl_n;
            ready_q    <= (state_n == IDLE);
            busy_q     <= (state_n != IDLE);
            done_q     <= finish;
            done_ab_q  <= finish && aborted_n;
        end
    end

    assign req.req_ready = ready_q;
    assign ctrl1         = ctrl_q[0];
    assign ctrl2         = ctrl_q[1];
    assign ctrl3         = ctrl_q[2];
    assign ctrl4         = ctrl_q[3];
    assign busy          = busy_q;
    assign done          = done_q;
    assign done_aborted  = done_ab_q;

endmodule

// File: tb/tb_mux_valve_sequencer.sv
// Directed bench for mux_valve_sequencer with SETTLE_CYCLES=4: hand-derived valve windows
// per route, back-to-back accepts, aborts in every phase, mid-route reset and idle abort.
module tb_mux_valve_sequencer;

    localparam int unsigned S       = 4;
    localparam int unsigned DWELL_W = 16;

    logic clk;
    logic rst_n;
    logic abort;
    logic ctrl1, ctrl2, ctrl3, ctrl4;
    logic busy, done, done_aborted;

    int vectors;
    int miscompares;

    mux_valve_sequencer_if #(.DWELL_W(DWELL_W)) req_if ();

    mux_valve_sequencer #(
        .SETTLE_CYCLES (S),
        .DWELL_W       (DWELL_W),
        .CLOSED_LEVEL  (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_if),
        .abort        (abort),
        .ctrl1        (ctrl1),
        .ctrl2        (ctrl2),
        .ctrl3        (ctrl3),
        .ctrl4        (ctrl4),
        .busy         (busy),
        .done         (done),
        .done_aborted (done_aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {ctrl4,ctrl3,ctrl2,ctrl1,busy,ready,done,done_aborted}
    localparam logic [7:0] IDLE_VEC = 8'b1111_0100;

    function automatic logic [7:0] observed();
        return {ctrl4, ctrl3, ctrl2, ctrl1, busy, req_if.req_ready, done, done_aborted};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Runs one route from the current negedge. Windows [lo,hi] are in cycles after the
    // accepting edge; d is the done cycle, rst_at (>=0) forces a reset after that cycle.
    task automatic route(input string name, input logic b, input logic [15:0] dw,
                         input int abort_at, input int o_lo, input int o_hi,
                         input int i_lo, input int i_hi, input int d, input logic ab,
                         input int rst_at, input int ncyc);
        logic [7:0] exp;
        logic oo, io;
        req_if.req_valid  = 1'b1;
        req_if.req_branch = b;
        req_if.req_dwell  = dw;
        abort             = (abort_at == 0);
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (rst_at >= 0 && k > rst_at) begin
                exp = IDLE_VEC;
            end else begin
                oo  = (k >= o_lo) && (k <= o_hi);
                io  = (k >= i_lo) && (k <= i_hi);
                exp = {!(b && oo), !(!b && oo), !(b && io), !(!b && io),
                       (k < d), (k == d), (k == d), (k == d) && ab};
            end
            check($sformatf("%s_c%0d", name, k), observed(), exp);
            if (k == 1) begin
                req_if.req_branch = ~b;
                req_if.req_dwell  = 16'hFFFF;
            end
            abort = (k == abort_at);
            if (k == rst_at) begin
                rst_n            = 1'b0;
                req_if.req_valid = 1'b0;
            end
            if (rst_at >= 0 && k == rst_at + 1) begin
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        rst_n             = 1'b0;
        abort             = 1'b0;
        req_if.req_valid  = 1'b0;
        req_if.req_branch = 1'b0;
        req_if.req_dwell  = '0;
        repeat (2) @(negedge clk);
        check("reset", observed(), IDLE_VEC);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset", observed(), IDLE_VEC);

        // Back-to-back routes with alternating branches; req_valid stays high throughout
        route("b0_dw10",     1'b0, 16'd10,   -1, 1, 22, 5, 18, 27, 1'b0, -1, 27);
        route("b1_dw0",      1'b1, 16'd0,    -1, 1, 12, 5,  8, 17, 1'b0, -1, 17);
        route("b0_ab_dwell", 1'b0, 16'd100,  12, 1, 16, 5, 12, 21, 1'b1, -1, 21);
        route("b1_ab_oout",  1'b1, 16'd100,   2, 1,  2, 1,  0,  7, 1'b1, -1,  7);
        route("b0_ab_cin",   1'b0, 16'd3,    13, 1, 15, 5, 11, 20, 1'b1, -1, 20);
        route("b1_ab_cout",  1'b1, 16'd3,    19, 1, 15, 5, 11, 20, 1'b1, -1, 20);
        route("b0_ab_acc",   1'b0, 16'd2,     0, 1, 14, 5, 10, 19, 1'b0, -1, 19);
        route("b1_reset",    1'b1, 16'd10,   -1, 1, 10, 5, 10, 99, 1'b0, 10, 14);

        // Abort while idle must not start anything nor flag the next result
        abort = 1'b1;
        @(negedge clk);
        check("idle_abort0", observed(), IDLE_VEC);
        @(negedge clk);
        check("idle_abort1", observed(), IDLE_VEC);
        abort = 1'b0;
        route("b0_dw1",      1'b0, 16'd1,    -1, 1, 13, 5,  9, 18, 1'b0, -1, 18);
        req_if.req_valid = 1'b0;
        @(negedge clk);
        check("final_idle", observed(), IDLE_VEC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
